tlul_led_master_arbiter: RTL and testbench
==========================================

// Module: tlul_led_master_arbiter
// PURPOSE
//  Single-outstanding TL-UL master that shares the LED slave (tlulSlaveLeds) among NUM_REQ local requesters.
//  It arbitrates requests round-robin, issues one PutFullData or Get per grant on the A channel,
//  and routes the D-channel response back to the granted requester.
//  It sits between board-level producers (pattern generator, buttons, debug) and the LED slave port.
// PARAMETERS
//  NUM_REQ   2    number of requesters (>=1); A source ID = requester index
//  ADDR_W    4    TL-UL address width
//  DATA_W    8    data width; a_mask width DATA_W/8, always all-ones
//  SOURCE_W  2    a_source/d_source width (2**SOURCE_W >= NUM_REQ)
//  TIMEOUT   255  D_WAIT cycles before error completion; 0 disables timeout
// PORTS
//  i_clk          in   1                clock, all logic rising-edge
//  i_reset_n      in   1                reset, asynchronous, active-low
//  i_req          in   NUM_REQ          per-requester request, held until grant
//  i_req_we       in   NUM_REQ          1=write (PutFullData), 0=read (Get)
//  i_req_addr     in   NUM_REQ*ADDR_W   packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//  i_req_wdata    in   NUM_REQ*DATA_W   packed write data
//  o_req_grant    out  NUM_REQ          one-hot 1-cycle pulse, request accepted
//  o_rsp_valid    out  NUM_REQ          one-hot 1-cycle pulse, response for requester k
//  o_rsp_data     out  DATA_W           read data, valid with o_rsp_valid
//  o_rsp_err      out  1                error flag, valid with o_rsp_valid
//  o_a_valid      out  1                TL-UL A valid
//  i_a_ready      in   1                TL-UL A ready
//  o_a_opcode     out  3                0=PutFullData, 4=Get
//  o_a_address    out  ADDR_W           A address
//  o_a_data       out  DATA_W           A data (0 for Get)
//  o_a_mask       out  DATA_W/8         all ones
//  o_a_source     out  SOURCE_W         granted requester index
//  i_d_valid      in   1                TL-UL D valid
//  o_d_ready      out  1                TL-UL D ready
//  i_d_opcode     in   3                0=AccessAck, 1=AccessAckData
//  i_d_data       in   DATA_W           D data
//  i_d_source     in   SOURCE_W         D source
//  i_d_error      in   1                D error
// BEHAVIOUR
//  - Reset (async assert): state IDLE, all outputs 0 except o_a_mask; RR pointer = NUM_REQ-1 so requester 0 is first.
//    An in-flight transaction is abandoned: no grant or response is issued for it.
//  - FSM states: IDLE -> A_SEND -> D_WAIT -> IDLE. All outputs are registered.
//  - IDLE: if any i_req is set, select the first set bit searching from pointer+1 (wrapping).
//    At the same edge: capture we/addr/wdata, set pointer to the winner, assert o_req_grant[k] for 1 cycle,
//    assert o_a_valid and drive the A fields, go to A_SEND.
//    A request is seen in cycle N, grant and A valid appear in cycle N+1.
//  - A_SEND: o_a_valid and all A fields are held stable until i_a_ready is sampled 1.
//    On that edge: o_a_valid=0, go to D_WAIT, clear the timeout counter.
//  - o_d_ready=1 in IDLE and D_WAIT, 0 in A_SEND.
//    Any D beat not matching the outstanding source, or arriving in IDLE, is consumed and dropped.
//  - D_WAIT: on a D beat with i_d_source==k, pulse o_rsp_valid[k] next cycle and go to IDLE.
//    o_rsp_data = i_d_data on AccessAckData, else 0.
//    o_rsp_err = i_d_error OR opcode mismatch (a write expects 0, a read expects 1).
//  - Timeout (TIMEOUT!=0): the counter increments each D_WAIT cycle. When it reaches TIMEOUT, pulse o_rsp_valid[k]
//    with o_rsp_err=1 and o_rsp_data=0, then go to IDLE. A late D beat is dropped.
//  - A matching D beat and the timeout in the same cycle: the D beat wins, and o_rsp_err follows the D beat.
//  - The earliest re-grant is the cycle after o_rsp_valid. Requesters drop i_req after their grant.
//    i_req held continuously yields alternating grants.
//  - Counter width is clog2(TIMEOUT+1). The pointer wraps NUM_REQ-1 -> 0.
// TESTING
//  - Write: req0 we=1 addr=0 wdata=0xA5, a_ready=1, AccessAck 2 cycles later -> grant[0], A op=0 data=0xA5 src=0,
//    rsp_valid[0] err=0.
//  - Read: req1 we=0 addr=1, AccessAckData data=0x3C src=1 -> A op=4 src=1, rsp_valid[1] data=0x3C err=0.
//  - Round-robin: req0 and req1 re-asserted after every grant for 4 transactions -> grant order 0,1,0,1.
//  - Backpressure: a_ready=0 for 5 cycles -> a_valid and fields stable, d_ready=0, handshake completes on cycle 6.
//  - Timeout: TIMEOUT=16, no D beat -> rsp_valid err=1 data=0 exactly 16 cycles after the A handshake.
//    A later D beat is consumed with no extra rsp.
//  - Reset in D_WAIT: all outputs 0 immediately. After release, req0 and req1 both high -> grant[0] first.

Source files
------------

// File: rtl/tlul_led_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tlul_led_master_arbiter
// Description : Single-outstanding TL-UL master that shares one LED slave
//               among NUM_REQ local requesters. Requests are arbitrated
//               round-robin. Each grant issues one PutFullData (write) or
//               Get (read) on the A channel. The D-channel response is routed
//               back to the granted requester. An optional D-channel timeout
//               completes the transaction with an error.
// Ports       : i_clk / i_reset_n       clock, async active-low reset
//               i_req .. i_req_wdata    packed per-requester request bus
//               o_req_grant             one-hot accept pulse
//               o_rsp_valid/data/err    one-hot response pulse plus payload
//               o_a_* / i_a_ready       TL-UL A channel (master side)
//               i_d_* / o_d_ready       TL-UL D channel (master side)
// Revision    : 1.0 - initial release
// ============================================================================
module tlul_led_master_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int SOURCE_W = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_wdata,
  output logic [NUM_REQ-1:0]        o_req_grant,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  output logic                      o_rsp_err,
  output logic                      o_a_valid,
  input  logic                      i_a_ready,
  output logic [2:0]                o_a_opcode,
  output logic [ADDR_W-1:0]         o_a_address,
  output logic [DATA_W-1:0]         o_a_data,
  output logic [DATA_W/8-1:0]       o_a_mask,
  output logic [SOURCE_W-1:0]       o_a_source,
  input  logic                      i_d_valid,
  output logic                      o_d_ready,
  input  logic [2:0]                i_d_opcode,
  input  logic [DATA_W-1:0]         i_d_data,
  input  logic [SOURCE_W-1:0]       i_d_source,
  input  logic                      i_d_error
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] OP_PUT_FULL  = 3'd0;
  localparam logic [2:0] OP_GET       = 3'd4;
  localparam logic [2:0] OP_ACK       = 3'd0;
  localparam logic [2:0] OP_ACK_DATA  = 3'd1;

  // Counter value seen on the cycle whose edge raises the timeout.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [PTR_W-1:0] PTR_INIT = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    A_SEND = 2'd1,
    D_WAIT = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   ptr, ptr_next;
  logic [PTR_W-1:0]   cur, cur_next;
  logic               cur_we, cur_we_next;
  logic [CNT_W-1:0]   cnt, cnt_next;

  logic [NUM_REQ-1:0] grant_next;
  logic [NUM_REQ-1:0] rsp_valid_next;
  logic [DATA_W-1:0]  rsp_data_next;
  logic               rsp_err_next;
  logic               a_valid_next;
  logic [2:0]         a_opcode_next;
  logic [ADDR_W-1:0]  a_address_next;
  logic [DATA_W-1:0]  a_data_next;
  logic [SOURCE_W-1:0] a_source_next;
  logic               d_ready_next;

  logic               found;
  logic [PTR_W-1:0]   winner;
  int                 idx;
  logic               d_hit;
  logic               timeout_hit;

  assign o_a_mask = '1;

  // Round-robin search starting one past the last winner, wrapping once.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + 1 + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (!found && i_req[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  // A beat is only accepted while d_ready is high; beats for other sources
  // are still consumed (d_ready stays high) but never produce a response.
  assign d_hit       = i_d_valid && o_d_ready && (i_d_source == o_a_source);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    cur_next       = cur;
    cur_we_next    = cur_we;
    cnt_next       = cnt;
    grant_next     = '0;
    rsp_valid_next = '0;
    rsp_data_next  = '0;
    rsp_err_next   = 1'b0;
    a_valid_next   = o_a_valid;
    a_opcode_next  = o_a_opcode;
    a_address_next = o_a_address;
    a_data_next    = o_a_data;
    a_source_next  = o_a_source;

    case (state)
      IDLE: begin
        if (found) begin
          state_next     = A_SEND;
          ptr_next       = winner;
          cur_next       = winner;
          cur_we_next    = i_req_we[winner];
          grant_next     = NUM_REQ'(1) << winner;
          a_valid_next   = 1'b1;
          a_opcode_next  = i_req_we[winner] ? OP_PUT_FULL : OP_GET;
          a_address_next = i_req_addr[winner*ADDR_W +: ADDR_W];
          a_data_next    = i_req_we[winner] ? i_req_wdata[winner*DATA_W +: DATA_W] : '0;
          a_source_next  = SOURCE_W'(winner);
        end
      end

      A_SEND: begin
        if (i_a_ready) begin
          a_valid_next = 1'b0;
          state_next   = D_WAIT;
          cnt_next     = '0;
        end
      end

      D_WAIT: begin
        cnt_next = cnt + 1'b1;
        // A matching beat takes priority over a simultaneous timeout.
        if (d_hit) begin
          state_next     = IDLE;
          rsp_valid_next = NUM_REQ'(1) << cur;
          rsp_data_next  = (i_d_opcode == OP_ACK_DATA) ? i_d_data : '0;
          rsp_err_next   = i_d_error |
                           (cur_we ? (i_d_opcode != OP_ACK) : (i_d_opcode != OP_ACK_DATA));
        end else if (timeout_hit) begin
          state_next     = IDLE;
          rsp_valid_next = NUM_REQ'(1) << cur;
          rsp_err_next   = 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    d_ready_next = (state_next != A_SEND);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= IDLE;
      ptr         <= PTR_INIT;
      cur         <= '0;
      cur_we      <= 1'b0;
      cnt         <= '0;
      o_req_grant <= '0;
      o_rsp_valid <= '0;
      o_rsp_data  <= '0;
      o_rsp_err   <= 1'b0;
      o_a_valid   <= 1'b0;
      o_a_opcode  <= '0;
      o_a_address <= '0;
      o_a_data    <= '0;
      o_a_source  <= '0;
      o_d_ready   <= 1'b0;
    end else begin
      state       <= state_next;
      ptr         <= ptr_next;
      cur         <= cur_next;
      cur_we      <= cur_we_next;
      cnt         <= cnt_next;
      o_req_grant <= grant_next;
      o_rsp_valid <= rsp_valid_next;
      o_rsp_data  <= rsp_data_next;
      o_rsp_err   <= rsp_err_next;
      o_a_valid   <= a_valid_next;
      o_a_opcode  <= a_opcode_next;
      o_a_address <= a_address_next;
      o_a_data    <= a_data_next;
      o_a_source  <= a_source_next;
      o_d_ready   <= d_ready_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlul_led_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tlul_led_master_arbiter
// Description : Self-checking bench for tlul_led_master_arbiter (2 requesters,
//               TIMEOUT=16) with a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tlul_led_master_arbiter;

  localparam int NR = 2;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int TO = 16;

  logic            i_clk = 1'b0;
  logic            i_reset_n = 1'b0;
  logic [NR-1:0]   i_req = '0;
  logic [NR-1:0]   i_req_we = '0;
  logic [NR*AW-1:0] i_req_addr = '0;
  logic [NR*DW-1:0] i_req_wdata = '0;
  logic [NR-1:0]   o_req_grant;
  logic [NR-1:0]   o_rsp_valid;
  logic [DW-1:0]   o_rsp_data;
  logic            o_rsp_err;
  logic            o_a_valid;
  logic            i_a_ready = 1'b0;
  logic [2:0]      o_a_opcode;
  logic [AW-1:0]   o_a_address;
  logic [DW-1:0]   o_a_data;
  logic [DW/8-1:0] o_a_mask;
  logic [SW-1:0]   o_a_source;
  logic            i_d_valid = 1'b0;
  logic            o_d_ready;
  logic [2:0]      i_d_opcode = '0;
  logic [DW-1:0]   i_d_data = '0;
  logic [SW-1:0]   i_d_source = '0;
  logic            i_d_error = 1'b0;

  tlul_led_master_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .SOURCE_W(SW), .TIMEOUT(TO)
  ) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_req(i_req), .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_req_grant(o_req_grant), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_rsp_err(o_rsp_err), .o_a_valid(o_a_valid), .i_a_ready(i_a_ready),
    .o_a_opcode(o_a_opcode), .o_a_address(o_a_address), .o_a_data(o_a_data),
    .o_a_mask(o_a_mask), .o_a_source(o_a_source), .i_d_valid(i_d_valid),
    .o_d_ready(o_d_ready), .i_d_opcode(i_d_opcode), .i_d_data(i_d_data),
    .i_d_source(i_d_source), .i_d_error(i_d_error)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Reference model: index of the most recently granted requester.
  int last = NR - 1;

  // Observations of one transaction.
  logic [18:0] ob_a;     // {grant, opcode, address, data, source}
  logic [10:0] ob_d;     // {rsp_valid, rsp_data, rsp_err}
  bit          ob_ok;    // A fields stable, d_ready correct, no stray responses
  int          ob_gwait;
  int          ob_lat;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [NR-1:0] m);
    for (int i = 1; i <= NR; i++) begin
      int k;
      k = (last + i) % NR;
      if (m[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [18:0] exp_a(input int w);
    logic we;
    we = i_req_we[w];
    return {2'(2'b01 << w), (we ? 3'd0 : 3'd4), i_req_addr[w*AW +: AW],
            (we ? i_req_wdata[w*DW +: DW] : 8'h00), SW'(w)};
  endfunction

  function automatic logic [10:0] exp_d(input int w, input logic we, input logic [2:0] op,
                                        input logic [7:0] dat, input logic err);
    logic e;
    e = err | (we ? (op != 3'd0) : (op != 3'd1));
    return {2'(2'b01 << w), ((op == 3'd1) ? dat : 8'h00), e};
  endfunction

  // Plays slave for one transaction. d_delay < 0 means no D beat is sent.
  task automatic run_txn(input int a_wait, input int d_delay, input logic [SW-1:0] d_src,
                         input logic [2:0] d_op, input logic [7:0] d_dat, input logic d_err,
                         input bit stray);
    int cyc;
    ob_a = '0; ob_d = '0; ob_ok = 1'b1; ob_gwait = -1; ob_lat = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (o_req_grant != '0) begin
        ob_gwait = c;
        break;
      end
    end
    if (ob_gwait < 0) return;
    ob_a = {o_req_grant, o_a_opcode, o_a_address, o_a_data, o_a_source};
    if (o_a_valid !== 1'b1 || o_d_ready !== 1'b0) ob_ok = 1'b0;
    i_req = i_req & ~o_req_grant;
    for (int w = 0; w < a_wait; w++) begin
      tick();
      if (o_a_valid !== 1'b1 || o_d_ready !== 1'b0 || o_req_grant !== '0 ||
          {o_a_opcode, o_a_address, o_a_data, o_a_source} !== ob_a[16:0]) ob_ok = 1'b0;
    end
    i_a_ready = 1'b1;
    tick();
    i_a_ready = 1'b0;
    if (o_a_valid !== 1'b0 || o_d_ready !== 1'b1) ob_ok = 1'b0;
    cyc = 0;
    if (stray) begin
      i_d_valid = 1'b1; i_d_source = d_src ^ SW'(1); i_d_opcode = d_op;
      i_d_data = d_dat; i_d_error = d_err;
      tick(); cyc++;
      i_d_valid = 1'b0;
      if (o_rsp_valid !== '0) ob_ok = 1'b0;
    end
    if (d_delay >= 0) begin
      while (cyc < d_delay) begin
        tick(); cyc++;
        if (o_rsp_valid !== '0) ob_ok = 1'b0;
      end
      i_d_valid = 1'b1; i_d_source = d_src; i_d_opcode = d_op;
      i_d_data = d_dat; i_d_error = d_err;
      tick(); cyc++;
      i_d_valid = 1'b0;
      if (o_rsp_valid != '0) ob_lat = cyc;
      ob_d = {o_rsp_valid, o_rsp_data, o_rsp_err};
    end else begin
      for (int c = 0; c < 60; c++) begin
        tick(); cyc++;
        if (o_rsp_valid != '0) begin
          ob_lat = cyc;
          ob_d = {o_rsp_valid, o_rsp_data, o_rsp_err};
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({o_req_grant, o_rsp_valid, o_rsp_data, o_rsp_err, o_a_valid, o_a_opcode,
         o_a_address, o_a_data, o_a_source, o_d_ready} !== '0 || o_a_mask !== 1'b1) begin
      errors++;
      $display("FAIL reset_outputs: got grant=%h rv=%h av=%b dr=%b mask=%h, want all 0 mask=1",
               o_req_grant, o_rsp_valid, o_a_valid, o_d_ready, o_a_mask);
    end
    i_reset_n = 1'b1;
    tick();
    checks++;
    if ({o_d_ready, o_a_valid, o_req_grant} !== {1'b1, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL idle_after_reset: got dr=%b av=%b grant=%h want 1 0 0",
               o_d_ready, o_a_valid, o_req_grant);
    end
  endtask

  task automatic test_write();
    logic [18:0] ea;
    i_req_we = 2'b01; i_req_addr = {4'h9, 4'h0}; i_req_wdata = {8'h11, 8'hA5}; i_req = 2'b01;
    ea = exp_a(rr_pick(i_req));
    run_txn(0, 2, 2'd0, 3'd0, 8'hEE, 1'b0, 1'b0);
    last = 0;
    checks++;
    if (ob_a !== ea || ob_gwait != 1 || !ob_ok) begin
      errors++;
      $display("FAIL write_a: got %h wait=%0d ok=%0b want %h wait=1 ok=1", ob_a, ob_gwait, ob_ok, ea);
    end
    checks++;
    if (ob_d !== exp_d(0, 1'b1, 3'd0, 8'hEE, 1'b0) || ob_lat != 3) begin
      errors++;
      $display("FAIL write_d: got %h lat=%0d want %h lat=3", ob_d, ob_lat, exp_d(0, 1'b1, 3'd0, 8'hEE, 1'b0));
    end
    i_req = '0;
  endtask

  task automatic test_read();
    logic [18:0] ea;
    i_req_we = 2'b00; i_req_addr = {4'h1, 4'h7}; i_req_wdata = {8'h5A, 8'h00}; i_req = 2'b10;
    ea = exp_a(rr_pick(i_req));
    run_txn(0, 1, 2'd1, 3'd1, 8'h3C, 1'b0, 1'b0);
    last = 1;
    checks++;
    if (ob_a !== ea || ob_gwait != 1 || !ob_ok) begin
      errors++;
      $display("FAIL read_a: got %h wait=%0d ok=%0b want %h", ob_a, ob_gwait, ob_ok, ea);
    end
    checks++;
    if (ob_d !== exp_d(1, 1'b0, 3'd1, 8'h3C, 1'b0) || ob_lat != 2) begin
      errors++;
      $display("FAIL read_d: got %h lat=%0d want %h lat=2", ob_d, ob_lat, exp_d(1, 1'b0, 3'd1, 8'h3C, 1'b0));
    end
    i_req = '0;
  endtask

  task automatic test_round_robin();
    for (int t = 0; t < 4; t++) begin
      int w;
      logic [18:0] ea;
      i_req_we = 2'($urandom); i_req_addr = 8'($urandom); i_req_wdata = 16'($urandom);
      i_req = 2'b11;
      w = rr_pick(i_req);
      ea = exp_a(w);
      run_txn(0, 0, SW'(w), i_req_we[w] ? 3'd0 : 3'd1, 8'h42, 1'b0, 1'b0);
      last = w;
      checks++;
      if (ob_a !== ea || ob_gwait != 1 || !ob_ok) begin
        errors++;
        $display("FAIL rr_grant_%0d: got %h wait=%0d want %h", t, ob_a, ob_gwait, ea);
      end
      checks++;
      if (ob_d !== exp_d(w, i_req_we[w], i_req_we[w] ? 3'd0 : 3'd1, 8'h42, 1'b0)) begin
        errors++;
        $display("FAIL rr_rsp_%0d: got %h want %h", t, ob_d,
                 exp_d(w, i_req_we[w], i_req_we[w] ? 3'd0 : 3'd1, 8'h42, 1'b0));
      end
    end
    i_req = '0;
  endtask

  task automatic test_backpressure();
    logic [18:0] ea;
    i_req_we = 2'b10; i_req_addr = {4'hC, 4'h3}; i_req_wdata = {8'h96, 8'h01}; i_req = 2'b10;
    ea = exp_a(rr_pick(i_req));
    run_txn(5, 1, 2'd1, 3'd0, 8'h00, 1'b1, 1'b0);
    last = 1;
    checks++;
    if (ob_a !== ea || !ob_ok) begin
      errors++;
      $display("FAIL backpressure_a: got %h ok=%0b want %h ok=1", ob_a, ob_ok, ea);
    end
    checks++;
    if (ob_d !== exp_d(1, 1'b1, 3'd0, 8'h00, 1'b1)) begin
      errors++;
      $display("FAIL backpressure_d: got %h want %h", ob_d, exp_d(1, 1'b1, 3'd0, 8'h00, 1'b1));
    end
    i_req = '0;
  endtask

  task automatic test_timeout();
    logic [NR-1:0] seen;
    i_req_we = 2'b00; i_req_addr = {4'h0, 4'h6}; i_req = 2'b01;
    run_txn(1, -1, 2'd0, 3'd1, 8'h00, 1'b0, 1'b0);
    last = 0;
    checks++;
    if (ob_d !== {2'b01, 8'h00, 1'b1} || ob_lat != TO) begin
      errors++;
      $display("FAIL timeout_rsp: got %h lat=%0d want %h lat=%0d", ob_d, ob_lat, {2'b01, 8'h00, 1'b1}, TO);
    end
    // Late beat for the timed-out transaction must be swallowed.
    i_d_valid = 1'b1; i_d_source = 2'd0; i_d_opcode = 3'd1; i_d_data = 8'h55; i_d_error = 1'b0;
    tick();
    i_d_valid = 1'b0;
    seen = o_rsp_valid;
    repeat (3) begin
      tick();
      seen = seen | o_rsp_valid;
    end
    checks++;
    if (seen !== '0 || o_d_ready !== 1'b1) begin
      errors++;
      $display("FAIL late_beat: got rsp=%h dr=%b want rsp=0 dr=1", seen, o_d_ready);
    end
    // Beat arriving on the same edge as the timeout wins.
    i_req = 2'b01;
    run_txn(0, TO - 1, 2'd0, 3'd1, 8'h77, 1'b0, 1'b0);
    last = 0;
    checks++;
    if (ob_d !== {2'b01, 8'h77, 1'b0} || ob_lat != TO) begin
      errors++;
      $display("FAIL timeout_tie: got %h lat=%0d want %h lat=%0d", ob_d, ob_lat, {2'b01, 8'h77, 1'b0}, TO);
    end
    i_req = '0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      int w, aw, dd;
      logic [2:0] op;
      logic [7:0] dat;
      logic de;
      bit st;
      logic [18:0] ea;
      logic [10:0] ed;
      i_req_we = 2'($urandom); i_req_addr = 8'($urandom); i_req_wdata = 16'($urandom);
      i_req = 2'($urandom_range(1, 3));
      w = rr_pick(i_req);
      ea = exp_a(w);
      if ($urandom_range(0, 3) == 0) op = 3'($urandom_range(0, 7));
      else op = i_req_we[w] ? 3'd0 : 3'd1;
      dat = 8'($urandom);
      de = ($urandom_range(0, 4) == 0);
      st = 1'($urandom_range(0, 1));
      dd = st ? $urandom_range(1, 5) : $urandom_range(0, 5);
      aw = $urandom_range(0, 3);
      ed = exp_d(w, i_req_we[w], op, dat, de);
      run_txn(aw, dd, SW'(w), op, dat, de, st);
      last = w;
      checks++;
      if (ob_a !== ea || ob_gwait != 1 || !ob_ok) begin
        errors++;
        $display("FAIL rand_a_%0d: got %h wait=%0d ok=%0b want %h", t, ob_a, ob_gwait, ob_ok, ea);
      end
      checks++;
      if (ob_d !== ed || ob_lat != dd + 1) begin
        errors++;
        $display("FAIL rand_d_%0d: got %h lat=%0d want %h lat=%0d", t, ob_d, ob_lat, ed, dd + 1);
      end
    end
    i_req = '0;
  endtask

  task automatic test_reset_in_dwait();
    i_req_we = 2'b01; i_req_addr = {4'h2, 4'h5}; i_req_wdata = {8'h00, 8'h3C}; i_req = 2'b01;
    tick();
    checks++;
    if (o_req_grant !== 2'b01) begin
      errors++;
      $display("FAIL pre_reset_grant: got %h want 01", o_req_grant);
    end
    i_req = '0;
    i_a_ready = 1'b1;
    tick();
    i_a_ready = 1'b0;
    #2 i_reset_n = 1'b0;
    #1;
    checks++;
    if ({o_req_grant, o_rsp_valid, o_rsp_data, o_rsp_err, o_a_valid, o_a_opcode,
         o_a_address, o_a_data, o_a_source, o_d_ready} !== '0 || o_a_mask !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got addr=%h data=%h av=%b dr=%b mask=%h want all 0 mask=1",
               o_a_address, o_a_data, o_a_valid, o_d_ready, o_a_mask);
    end
    i_req = 2'b11;
    tick();
    i_reset_n = 1'b1;
    last = NR - 1;
    tick();
    checks++;
    if (o_req_grant !== 2'(2'b01 << rr_pick(2'b11)) || o_rsp_valid !== '0) begin
      errors++;
      $display("FAIL post_reset_grant: got grant=%h rsp=%h want grant=%h rsp=0",
               o_req_grant, o_rsp_valid, 2'(2'b01 << rr_pick(2'b11)));
    end
    i_req = '0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_random();
    test_reset_in_dwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
